// File: rtl/rv_mem_pkg.sv
// ---------------------------------------------------------------------------
// rv_mem_pkg
// Shared constants and types for the RV memory blocks.
//   NOP_INSN          : canonical RISC-V NOP (addi x0,x0,0)
//   DEFAULT_INIT_WORD : default fill pattern written by the TCM init sweep
//   dmem_state_e      : TCM controller states (INIT sweep, RUN service)
//   merge_lanes()     : byte-lane merge of a new word over an old word
// ---------------------------------------------------------------------------
package rv_mem_pkg;

    localparam logic [31:0] NOP_INSN          = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_INIT_WORD = 32'hFFFF_FFFF;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } dmem_state_e;

    // Lane i of the result comes from new_w when be[i] is set, else from old_w.
    function automatic logic [31:0] merge_lanes(input logic [31:0] old_w,
                                                input logic [31:0] new_w,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/rv_rd_pipe.sv
// ---------------------------------------------------------------------------
// rv_rd_pipe
// RD_LAT-deep delay line for read responses (valid, error, data).
// Data stages only load when the stage feeding them is valid, so the last
// stage holds the most recent returned word while valid is low.
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous reset, ACTIVE-HIGH (legacy name kept)
//   vld_i   in   read response valid entering the line
//   err_i   in   out-of-range flag entering the line
//   data_i  in   read word entering the line
//   vld_o   out  valid after RD_LAT cycles
//   err_o   out  error after RD_LAT cycles
//   data_o  out  data after RD_LAT cycles (held while vld_o is low)
// ---------------------------------------------------------------------------
module rv_rd_pipe #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vld_i,
    input  logic        err_i,
    input  logic [31:0] data_i,
    output logic        vld_o,
    output logic        err_o,
    output logic [31:0] data_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [RD_LAT-1:0] err_q;
    logic [31:0]       data_q [RD_LAT];

    // Shift register: valid/error always advance, data advances with valid.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            vld_q <= {RD_LAT{1'b0}};
            err_q <= {RD_LAT{1'b0}};
            for (int s = 0; s < RD_LAT; s++) begin
                data_q[s] <= 32'h0000_0000;
            end
        end else begin
            vld_q[0] <= vld_i;
            err_q[0] <= err_i;
            if (vld_i) begin
                data_q[0] <= data_i;
            end
            for (int s = 1; s < RD_LAT; s++) begin
                vld_q[s] <= vld_q[s-1];
                err_q[s] <= err_q[s-1];
                if (vld_q[s-1]) begin
                    data_q[s] <= data_q[s-1];
                end
            end
        end
    end

    assign vld_o  = vld_q[RD_LAT-1];
    assign err_o  = err_q[RD_LAT-1];
    assign data_o = data_q[RD_LAT-1];

endmodule

// File: rtl/rv_dmem_tcm.sv
// ---------------------------------------------------------------------------
// rv_dmem_tcm
// Tightly-coupled data memory, DEPTH x 32-bit words, word addressed.
// After reset an INIT sweep writes INIT_WORD into every word (ready low);
// afterwards every cycle accepts one access with no stalls. Reads return
// after RD_LAT cycles through rv_rd_pipe; out-of-range accesses return an
// err pulse (reads also return 0 with rvalid).
// Optional feature macro: DMEM_MMIO_EN -- word MMIO_ADDR becomes a sticky
// "program done" register instead of memory.
// Ports:
//   clk        in   clock
//   rst_n      in   asynchronous reset, ACTIVE-HIGH (legacy name kept)
//   req        in   access request
//   addr       in   word address (AW bits)
//   we         in   byte-lane write enables, 4'b0000 = read
//   wdata      in   write data
//   ready      out  access accepted when req && ready
//   rdata      out  read data, held while rvalid is low
//   rvalid     out  one-cycle pulse per accepted read
//   err        out  one-cycle pulse per out-of-range access
//   done_flag  out  sticky program-done flag (0 unless DMEM_MMIO_EN)
// ---------------------------------------------------------------------------
module rv_dmem_tcm
    import rv_mem_pkg::*;
#(
    parameter int          DEPTH       = 512,
    parameter int          AW          = 32,
    parameter int          RD_LAT      = 1,
    parameter int          WRITE_FIRST = 1,
    parameter logic [31:0] INIT_WORD   = DEFAULT_INIT_WORD,
    parameter int          MMIO_ADDR   = DEPTH - 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic          ready,
    output logic [31:0]   rdata,
    output logic          rvalid,
    output logic          err,
    output logic          done_flag
);

    localparam int            IW      = $clog2(DEPTH);
    localparam logic [AW-1:0] DEPTH_A = AW'(DEPTH);
    localparam logic [AW-1:0] MMIO_A  = AW'(MMIO_ADDR);
    localparam logic [IW-1:0] LAST_W  = IW'(DEPTH - 1);
`ifdef DMEM_MMIO_EN
    localparam logic          MMIO_EN = 1'b1;
`else
    localparam logic          MMIO_EN = 1'b0;
`endif

    dmem_state_e   state_q;
    logic [IW-1:0] init_cnt_q;
    logic          ready_q;
    logic [31:0]   mem_q [DEPTH];

    logic          acc_s;
    logic          in_range_s;
    logic          mmio_hit_s;
    logic          mmio_wr_s;
    logic [IW-1:0] idx_s;
    logic          wr_en_s;
    logic [IW-1:0] wr_idx_s;
    logic [3:0]    wr_be_s;
    logic [31:0]   wr_data_s;
    logic          rd_vld_s;
    logic          rd_err_s;
    logic [31:0]   rd_word_s;

    // Controller FSM: INIT sweep counter, then RUN with ready held high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= ST_INIT;
            init_cnt_q <= {IW{1'b0}};
            ready_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    if (init_cnt_q == LAST_W) begin
                        state_q    <= ST_RUN;
                        ready_q    <= 1'b1;
                        init_cnt_q <= {IW{1'b0}};
                    end else begin
                        init_cnt_q <= init_cnt_q + IW'(1);
                    end
                end
                ST_RUN: begin
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q    <= ST_INIT;
                    ready_q    <= 1'b0;
                    init_cnt_q <= {IW{1'b0}};
                end
            endcase
        end
    end

    // Access decode: range check on all AW bits before the index is used.
    always_comb begin
        acc_s      = req & ready_q;
        in_range_s = (addr < DEPTH_A);
        idx_s      = addr[IW-1:0];
        mmio_hit_s = MMIO_EN & in_range_s & (addr == MMIO_A);
        mmio_wr_s  = acc_s & (we != 4'b0000) & mmio_hit_s;
        rd_vld_s   = acc_s & (we == 4'b0000);
        rd_err_s   = acc_s & ~in_range_s;

        // The sweep owns the write port until RUN.
        if (state_q == ST_INIT) begin
            wr_en_s   = 1'b1;
            wr_idx_s  = init_cnt_q;
            wr_be_s   = 4'b1111;
            wr_data_s = INIT_WORD;
        end else begin
            wr_en_s   = acc_s & (we != 4'b0000) & in_range_s & ~mmio_hit_s;
            wr_idx_s  = idx_s;
            wr_be_s   = we;
            wr_data_s = wdata;
        end

        // The single port never carries a read and a store in one cycle;
        // the collision select still defines which word a shared path sees.
        if (!in_range_s) begin
            rd_word_s = 32'h0000_0000;
        end else if (mmio_hit_s) begin
            rd_word_s = {31'b0, done_flag};
        end else if ((WRITE_FIRST != 0) && wr_en_s && (wr_idx_s == idx_s)) begin
            rd_word_s = merge_lanes(mem_q[idx_s], wr_data_s, wr_be_s);
        end else begin
            rd_word_s = mem_q[idx_s];
        end
    end

    // Storage array: byte-lane writes, contents not reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en_s && wr_be_s[i]) begin
                mem_q[wr_idx_s][8*i +: 8] <= wr_data_s[8*i +: 8];
            end
        end
    end

`ifdef DMEM_MMIO_EN
    logic done_q;

    // Sticky done flag, set by any store to the MMIO word.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            done_q <= 1'b0;
        end else if (mmio_wr_s) begin
            done_q <= 1'b1;
        end else begin
            done_q <= done_q;
        end
    end

    assign done_flag = done_q;
`else
    assign done_flag = 1'b0;
`endif

    rv_rd_pipe #(
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (rd_vld_s),
        .err_i  (rd_err_s),
        .data_i (rd_word_s),
        .vld_o  (rvalid),
        .err_o  (err),
        .data_o (rdata)
    );

    assign ready = ready_q;

endmodule

// File: tb/tb_rv_dmem_tcm.sv
// ---------------------------------------------------------------------------
// tb_rv_dmem_tcm
// Directed bench for rv_dmem_tcm (DEPTH=128, RD_LAT=3). Inputs change and
// outputs are sampled on the falling clock edge. Expectations for the MMIO
// word follow the DMEM_MMIO_EN build setting.
// ---------------------------------------------------------------------------
module tb_rv_dmem_tcm;

    localparam int DEPTH  = 128;
    localparam int AW     = 32;
    localparam int RD_LAT = 3;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          req   = 1'b0;
    logic [AW-1:0] addr  = '0;
    logic [3:0]    we    = 4'b0000;
    logic [31:0]   wdata = 32'h0;
    logic          ready;
    logic [31:0]   rdata;
    logic          rvalid;
    logic          err;
    logic          done_flag;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    rv_dmem_tcm #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .RD_LAT      (RD_LAT),
        .WRITE_FIRST (1),
        .INIT_WORD   (32'hFFFF_FFFF),
        .MMIO_ADDR   (DEPTH - 1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .addr      (addr),
        .we        (we),
        .wdata     (wdata),
        .ready     (ready),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .err       (err),
        .done_flag (done_flag)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [3:0] be, input logic [31:0] d);
        req = 1'b1; addr = a; we = be; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 4'b0000;
    endtask

    task automatic rd(input string tag, input logic [AW-1:0] a,
                      input logic [31:0] exp_d, input logic exp_e);
        req = 1'b1; addr = a; we = 4'b0000;
        for (int i = 1; i <= RD_LAT; i++) begin
            @(negedge clk);
            req = 1'b0;
            if (i < RD_LAT) chk({tag, "_early"}, {31'b0, rvalid}, 32'd0);
        end
        chk({tag, "_vld"},  {31'b0, rvalid}, 32'd1);
        chk({tag, "_data"}, rdata, exp_d);
        chk({tag, "_err"},  {31'b0, err}, {31'b0, exp_e});
        @(negedge clk);
        chk({tag, "_pulse"}, {31'b0, rvalid | err}, 32'd0);
        chk({tag, "_hold"},  rdata, exp_d);
    endtask

    // Requests that must be ignored while ready is low.
    task automatic junk(input int i);
        req   = 1'b1;
        addr  = (i % 3 == 0) ? AW'(DEPTH) : AW'(5);
        we    = (i % 2 == 0) ? 4'b1111 : 4'b0000;
        wdata = 32'h0000_0000;
    endtask

    // Called right after reset release: ready must rise after exactly DEPTH edges.
    task automatic sweep(input string tag);
        int early = 0;
        int spur  = 0;
        for (int i = 1; i < DEPTH; i++) begin
            junk(i);
            @(negedge clk);
            if (ready) early++;
            if (rvalid | err) spur++;
        end
        req = 1'b0; we = 4'b0000;
        @(negedge clk);
        chk({tag, "_ready_early"}, early, 32'd0);
        chk({tag, "_spurious"}, spur, 32'd0);
        chk({tag, "_ready_rise"}, {31'b0, ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] exp_mmio_rd;
        logic [31:0] exp_mmio_fill;
        logic        exp_done;
        int          spur;
`ifdef DMEM_MMIO_EN
        exp_done      = 1'b1;
        exp_mmio_rd   = 32'h0000_0001;
        exp_mmio_fill = 32'h0000_0000;
`else
        exp_done      = 1'b0;
        exp_mmio_rd   = 32'hDEAD_0001;
        exp_mmio_fill = 32'hFFFF_FFFF;
`endif
        repeat (2) @(negedge clk);
        chk("rst_ready",  {31'b0, ready},     32'd0);
        chk("rst_rvalid", {31'b0, rvalid},    32'd0);
        chk("rst_err",    {31'b0, err},       32'd0);
        chk("rst_rdata",  rdata,              32'd0);
        chk("rst_done",   {31'b0, done_flag}, 32'd0);

        rst_n = 1'b0;
        sweep("init0");

        rd("w5_init", AW'(5), 32'hFFFF_FFFF, 1'b0);

        wr(AW'(3), 4'b1111, 32'h1234_5678);
        wr(AW'(3), 4'b0010, 32'h0000_AB00);
        rd("w3_lane", AW'(3), 32'h1234_AB78, 1'b0);

        wr(AW'(10), 4'b1111, 32'hCAFE_F00D);
        rd("raw10", AW'(10), 32'hCAFE_F00D, 1'b0);

        wr(AW'(11), 4'b1001, 32'hAABB_CCDD);
        rd("w11_lane", AW'(11), 32'hAAFF_FFDD, 1'b0);

        for (int i = 0; i < 8; i++) wr(AW'(i), 4'b1111, 32'h1000_0000 + 32'(i));

        // Back-to-back reads of words 0..7.
        req = 1'b1; addr = AW'(0); we = 4'b0000;
        for (int j = 1; j <= RD_LAT + 8; j++) begin
            @(negedge clk);
            if (j < 8) addr = AW'(j);
            else req = 1'b0;
            if (j >= RD_LAT && j < RD_LAT + 8) begin
                chk("b2b_vld",  {31'b0, rvalid}, 32'd1);
                chk("b2b_data", rdata, 32'h1000_0000 + 32'(j - RD_LAT));
            end else begin
                chk("b2b_idle", {31'b0, rvalid}, 32'd0);
            end
        end

        rd("oor_rd", AW'(DEPTH), 32'h0000_0000, 1'b1);
        rd("oor_hi", 32'h8000_0005, 32'h0000_0000, 1'b1);

        // Out-of-range write: err pulse, no rvalid, no store.
        req = 1'b1; addr = AW'(DEPTH); we = 4'b1111; wdata = 32'h0;
        for (int i = 1; i <= RD_LAT; i++) begin
            @(negedge clk);
            req = 1'b0; we = 4'b0000;
        end
        chk("oor_wr_err",    {31'b0, err},    32'd1);
        chk("oor_wr_rvalid", {31'b0, rvalid}, 32'd0);
        @(negedge clk);
        chk("oor_wr_pulse",  {31'b0, err},    32'd0);
        wr(32'h0001_0003, 4'b1111, 32'h0);
        repeat (RD_LAT + 1) @(negedge clk);
        rd("oor_w0", AW'(0), 32'h1000_0000, 1'b0);
        rd("oor_w3", AW'(3), 32'h1000_0003, 1'b0);

        wr(AW'(DEPTH - 1), 4'b1111, 32'hDEAD_0001);
        chk("done_set",  {31'b0, done_flag}, {31'b0, exp_done});
        repeat (4) @(negedge clk);
        chk("done_hold", {31'b0, done_flag}, {31'b0, exp_done});
        rd("mmio_rd", AW'(DEPTH - 1), exp_mmio_rd, 1'b0);

        // Reset while a read is in flight: it must be dropped.
        req = 1'b1; addr = AW'(5); we = 4'b0000;
        @(negedge clk);
        req = 1'b0; rst_n = 1'b1;
        spur = 0;
        repeat (RD_LAT + 1) begin
            @(negedge clk);
            if (rvalid) spur++;
        end
        chk("rst_drop",   spur,               32'd0);
        chk("rst2_done",  {31'b0, done_flag}, 32'd0);
        chk("rst2_ready", {31'b0, ready},     32'd0);

        // Restart the sweep once the counter has reached 100.
        rst_n = 1'b0;
        spur = 0;
        for (int i = 0; i < 100; i++) begin
            junk(i);
            @(negedge clk);
            if (ready | rvalid | err) spur++;
        end
        req = 1'b0; we = 4'b0000; rst_n = 1'b1;
        chk("mid_init_quiet", spur, 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        sweep("init2");

        rd("w5_refill",  AW'(5), 32'hFFFF_FFFF, 1'b0);
        rd("w3_refill",  AW'(3), 32'hFFFF_FFFF, 1'b0);
        rd("mmio_after", AW'(DEPTH - 1), exp_mmio_fill, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
